mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  - Memory-access stage of the RISC-V pipeline, between EX and WB. Issues load/store requests to data
//    memory over a req/ack bus and formats load data (lane select, sign/zero extension).
//  - Produces the alu_i / d_mem_i / wb_mem_sel_i operands consumed by the writeback stage, registered, with a
//    valid strobe. Stalls upstream while a bus transaction is outstanding.
// PARAMETERS
//  ACK_TIMEOUT  255  max cycles in REQ waiting for dm_ack_i before abort (1..65535)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  ex_valid_i    in   1   EX presents an instruction this cycle
//  alu_i         in   32  ALU result; effective address for loads/stores
//  rs2_i         in   32  store data
//  mem_rd_i      in   1   instruction is a load
//  mem_wr_i      in   1   instruction is a store (mem_rd_i & mem_wr_i never both 1)
//  funct3_i      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  wb_mem_sel_i  in   1   passed to WB: 1 = write back load data
//  stall_o       out  1   upstream must hold its instruction (EX not accepted)
//  dm_req_o      out  1   bus request, held until ack/abort
//  dm_we_o       out  1   1 = write
//  dm_addr_o     out  32  word address ({alu_i[31:2],2'b00})
//  dm_wdata_o    out  32  store data, replicated into lanes
//  dm_be_o       out  4   byte enables
//  dm_ack_i      in   1   bus completes the request this cycle; dm_rdata_i valid on loads
//  dm_rdata_i    in   32  read data
//  wb_valid_o    out  1   WB operands valid (1-cycle pulse per instruction)
//  alu_o         out  32  registered alu_i
//  d_mem_o       out  32  formatted load data (0 for non-loads)
//  wb_mem_sel_o  out  1   registered wb_mem_sel_i
//  misalign_o    out  1   1-cycle pulse: misaligned access dropped
//  bus_err_o     out  1   1-cycle pulse: ACK_TIMEOUT expired, access aborted
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, timeout counter 0, every output 0 incl. dm_req_o; takes effect
//    immediately even mid-transaction; an ack arriving after reset is ignored.
//  - States: IDLE, REQ. stall_o = (state==REQ). Instruction accepted when ex_valid_i & state==IDLE.
//  - IDLE, accepted non-memory op: next cycle wb_valid_o=1, alu_o/wb_mem_sel_o registered, d_mem_o=0. Latency 1.
//  - IDLE, accepted mem op, aligned: latch addr/we/wdata/be/funct3/alu/wb_mem_sel; -> REQ; dm_req_o=1 from next cycle.
//  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no bus request, stay IDLE, next cycle misalign_o=1, wb_valid_o=0.
//  - Unlisted funct3 (011,110,111) treated as W.
//  - REQ: dm_req_o/we/addr/wdata/be stable until exit. On dm_ack_i: capture formatted rdata (loads), -> IDLE;
//    next cycle wb_valid_o=1, stall_o=0. Ack in first REQ cycle => result 2 cycles after accept.
//  - Timeout: counter counts REQ cycles without ack; at ACK_TIMEOUT -> IDLE, dm_req_o=0, next cycle bus_err_o=1,
//    wb_valid_o=0. Ack on the same cycle as expiry wins (normal completion).
//  - dm_ack_i while IDLE: ignored.
//  - Byte enables: B 0001<<addr[1:0]; H addr[1]?1100:0011; W 1111. dm_be_o=1111 for loads.
//  - Store data lanes: B {4{rs2[7:0]}}, H {2{rs2[15:0]}}, W rs2.
//  - Load format: select byte addr[1:0] / half addr[1]; B,H sign-extend to 32; BU,HU zero-extend; W as is.
//  - wb_valid_o, misalign_o, bus_err_o mutually exclusive, each at most 1 cycle per instruction.
// TESTING
//  - ALU op alu_i=0x1234_5678 -> next cycle wb_valid_o=1, alu_o=0x1234_5678, d_mem_o=0, stall_o never 1.
//  - LB addr 0x0000_0103, rdata 0x80FF_0000, ack after 3 REQ cycles -> be=1111, addr 0x100, stall_o 3 cycles, d_mem_o=0xFFFF_FF80.
//  - LHU addr 0x202, rdata 0xBEEF_1234, ack immediate -> d_mem_o=0x0000_BEEF, wb_valid_o 2 cycles after accept.
//  - SB addr 0x301, rs2=0x0000_00AB -> dm_we_o=1, be=0010, wdata=0xABAB_ABAB, addr 0x300; SW addr 0x302 -> misalign_o pulse, no dm_req_o.
//  - Load, never acked, ACK_TIMEOUT=4 -> dm_req_o 4 cycles, then bus_err_o pulse, wb_valid_o stays 0, stall_o drops.
//  - rst_n low during REQ -> dm_req_o/stall_o 0 immediately; late ack after release -> no wb_valid_o.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory req/ack transactions and formats load data for writeback.
// Latency: non-memory ops 1 cycle; memory ops 1 cycle after the cycle dm_ack_i is seen (2 minimum).
// Backpressure: stall_o is high while a bus request is outstanding; EX must hold its instruction.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] rs2_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  funct3_i,
    input  logic        wb_mem_sel_i,
    output logic        stall_o,
    output logic        dm_req_o,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [3:0]  dm_be_o,
    input  logic        dm_ack_i,
    input  logic [31:0] dm_rdata_i,
    output logic        wb_valid_o,
    output logic [31:0] alu_o,
    output logic [31:0] d_mem_o,
    output logic        wb_mem_sel_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [15:0] to_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] alu_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        rd_q;
    logic        sel_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        mem_op;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    // funct3[1:0] encodes the size; 10 and 11 (including unlisted codes) both mean word.
    assign is_b   = (funct3_i[1:0] == 2'b00);
    assign is_h   = (funct3_i[1:0] == 2'b01);
    assign is_w   = ~is_b & ~is_h;
    assign mem_op = mem_rd_i | mem_wr_i;

    assign misaligned = (is_h & alu_i[0]) | (is_w & (|alu_i[1:0]));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = rs2_i;
        if (!mem_rd_i) begin
            if (is_b) begin
                be_new    = 4'b0001 << alu_i[1:0];
                wdata_new = {4{rs2_i[7:0]}};
            end else if (is_h) begin
                be_new    = alu_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{rs2_i[15:0]}};
            end
        end
    end

    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'b0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'b0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            to_cnt       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            alu_q        <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            sel_q        <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            wb_valid_o   <= 1'b0;
            alu_o        <= '0;
            d_mem_o      <= '0;
            wb_mem_sel_o <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (!mem_op) begin
                            wb_valid_o   <= 1'b1;
                            alu_o        <= alu_i;
                            wb_mem_sel_o <= wb_mem_sel_i;
                            d_mem_o      <= '0;
                        end else if (misaligned) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state   <= REQ;
                            to_cnt  <= '0;
                            addr_q  <= {alu_i[31:2], 2'b00};
                            wdata_q <= wdata_new;
                            be_q    <= be_new;
                            we_q    <= mem_wr_i;
                            rd_q    <= mem_rd_i;
                            sel_q   <= wb_mem_sel_i;
                            f3_q    <= funct3_i;
                            off_q   <= alu_i[1:0];
                            alu_q   <= alu_i;
                        end
                    end
                end
                REQ: begin
                    // An ack on the expiry cycle still completes normally.
                    if (dm_ack_i) begin
                        state        <= IDLE;
                        to_cnt       <= '0;
                        wb_valid_o   <= 1'b1;
                        alu_o        <= alu_q;
                        wb_mem_sel_o <= sel_q;
                        d_mem_o      <= rd_q ? fmt_load(dm_rdata_i, off_q, f3_q) : 32'h0;
                    end else if (to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        to_cnt    <= '0;
                        bus_err_o <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall_o    = (state == REQ);
    assign dm_req_o   = (state == REQ);
    assign dm_we_o    = we_q;
    assign dm_addr_o  = addr_q;
    assign dm_wdata_o = wdata_q;
    assign dm_be_o    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/idle-ack sequences, then random traffic vs a reference model.
module tb_mem_stage;

    localparam int ACK_TO = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic [31:0] alu_i;
    logic [31:0] rs2_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  funct3_i;
    logic        wb_mem_sel_i;
    logic        stall_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_wdata_o;
    logic [3:0]  dm_be_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;
    logic        wb_valid_o;
    logic [31:0] alu_o;
    logic [31:0] d_mem_o;
    logic        wb_mem_sel_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid_i),
        .alu_i        (alu_i),
        .rs2_i        (rs2_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .funct3_i     (funct3_i),
        .wb_mem_sel_i (wb_mem_sel_i),
        .stall_o      (stall_o),
        .dm_req_o     (dm_req_o),
        .dm_we_o      (dm_we_o),
        .dm_addr_o    (dm_addr_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_be_o      (dm_be_o),
        .dm_ack_i     (dm_ack_i),
        .dm_rdata_i   (dm_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .alu_o        (alu_o),
        .d_mem_o      (d_mem_o),
        .wb_mem_sel_o (wb_mem_sel_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic        sel;
        int          delay;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dmem;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model, straight from the size/sign rules using arithmetic.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] d, input int off, input logic [2:0] f3);
        int unsigned v;
        case (f3)
            3'b000: begin
                v = (d >> (8 * off)) % 256;
                return (v >= 128) ? v + 32'hFFFF_FF00 : v;
            end
            3'b100: return (d >> (8 * off)) % 256;
            3'b001: begin
                v = (d >> (8 * off)) % 65536;
                return (v >= 32768) ? v + 32'hFFFF_0000 : v;
            end
            3'b101: return (d >> (8 * off)) % 65536;
            default: return d;
        endcase
    endfunction

    task automatic run_txn(input logic vld, input logic [31:0] alu, input logic [31:0] rs2,
                           input logic rd, input logic wr, input logic [2:0] f3, input logic sel,
                           input int delay, input logic [31:0] rdata, input logic exp_mis,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_dmem);
        bit done;
        ex_valid_i   = vld;
        alu_i        = alu;
        rs2_i        = rs2;
        mem_rd_i     = rd;
        mem_wr_i     = wr;
        funct3_i     = f3;
        wb_mem_sel_i = sel;
        step();
        ex_valid_i = 1'b0;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b0;
        if (!vld) begin
            chk("idle_wb_valid", wb_valid_o, 1'b0);
            chk("idle_stall", stall_o, 1'b0);
        end else if (!(rd | wr)) begin
            chk("alu_wb_valid", wb_valid_o, 1'b1);
            chk("alu_alu_o", alu_o, alu);
            chk("alu_d_mem", d_mem_o, 32'h0);
            chk("alu_sel", wb_mem_sel_o, sel);
            chk("alu_stall", stall_o, 1'b0);
        end else if (exp_mis) begin
            chk("mis_pulse", misalign_o, 1'b1);
            chk("mis_wb_valid", wb_valid_o, 1'b0);
            chk("mis_req", dm_req_o, 1'b0);
            chk("mis_stall", stall_o, 1'b0);
        end else begin
            chk("req_stall", stall_o, 1'b1);
            chk("req_req", dm_req_o, 1'b1);
            chk("req_addr", dm_addr_o, {alu[31:2], 2'b00});
            chk("req_we", dm_we_o, wr);
            chk("req_be", dm_be_o, exp_be);
            if (wr) chk("req_wdata", dm_wdata_o, exp_wdata);
            done = 1'b0;
            for (int k = 0; k < ACK_TO && !done; k++) begin
                if (k == delay) begin
                    dm_ack_i   = 1'b1;
                    dm_rdata_i = rdata;
                end
                step();
                dm_ack_i   = 1'b0;
                dm_rdata_i = $urandom;
                if (k == delay) begin
                    chk("ack_wb_valid", wb_valid_o, 1'b1);
                    chk("ack_alu_o", alu_o, alu);
                    chk("ack_d_mem", d_mem_o, exp_dmem);
                    chk("ack_sel", wb_mem_sel_o, sel);
                    chk("ack_stall", stall_o, 1'b0);
                    chk("ack_bus_err", bus_err_o, 1'b0);
                    done = 1'b1;
                end else if (k == ACK_TO - 1) begin
                    chk("to_bus_err", bus_err_o, 1'b1);
                    chk("to_wb_valid", wb_valid_o, 1'b0);
                    chk("to_stall", stall_o, 1'b0);
                    chk("to_req", dm_req_o, 1'b0);
                    done = 1'b1;
                end else begin
                    chk("wait_stall", stall_o, 1'b1);
                    chk("wait_req", dm_req_o, 1'b1);
                    chk("wait_addr", dm_addr_o, {alu[31:2], 2'b00});
                    chk("wait_be", dm_be_o, exp_be);
                end
            end
        end
        step();
        chk("post_wb_valid", wb_valid_o, 1'b0);
        chk("post_misalign", misalign_o, 1'b0);
        chk("post_bus_err", bus_err_o, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        ex_valid_i   = 1'b0;
        alu_i        = '0;
        rs2_i        = '0;
        mem_rd_i     = 1'b0;
        mem_wr_i     = 1'b0;
        funct3_i     = '0;
        wb_mem_sel_i = 1'b0;
        dm_ack_i     = 1'b0;
        dm_rdata_i   = '0;

        //          alu           rs2           rd wr f3      sel dly rdata         mis be       wdata         dmem
        tbl[0]  = '{32'h1234_5678, 32'h0,        0, 0, 3'b000, 1,  0,  32'h0,        0, 4'h0,    32'h0,        32'h0};
        tbl[1]  = '{32'h0000_0103, 32'h0,        1, 0, 3'b000, 1,  2,  32'h80FF_0000, 0, 4'hF,   32'h0,        32'hFFFF_FF80};
        tbl[2]  = '{32'h0000_0202, 32'h0,        1, 0, 3'b101, 1,  0,  32'hBEEF_1234, 0, 4'hF,   32'h0,        32'h0000_BEEF};
        tbl[3]  = '{32'h0000_0301, 32'h0000_00AB, 0, 1, 3'b000, 0,  1,  32'h5555_AAAA, 0, 4'b0010, 32'hABAB_ABAB, 32'h0};
        tbl[4]  = '{32'h0000_0302, 32'h1122_3344, 0, 1, 3'b010, 0,  0,  32'h0,        1, 4'h0,    32'h0,        32'h0};
        tbl[5]  = '{32'h0000_0002, 32'h0,        1, 0, 3'b001, 1,  1,  32'h8001_7FFF, 0, 4'hF,   32'h0,        32'hFFFF_8001};
        tbl[6]  = '{32'h0000_0010, 32'h0,        1, 0, 3'b010, 1,  3,  32'hDEAD_BEEF, 0, 4'hF,   32'h0,        32'hDEAD_BEEF};
        tbl[7]  = '{32'h0000_0101, 32'h0,        1, 0, 3'b100, 1,  0,  32'h0000_F200, 0, 4'hF,   32'h0,        32'h0000_00F2};
        tbl[8]  = '{32'h0000_0106, 32'h1234_CAFE, 0, 1, 3'b001, 0,  0,  32'h0,        0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
        tbl[9]  = '{32'h0000_0001, 32'h0,        1, 0, 3'b001, 1,  0,  32'h0,        1, 4'h0,    32'h0,        32'h0};
        tbl[10] = '{32'h0000_0002, 32'h0,        1, 0, 3'b011, 1,  0,  32'h0,        1, 4'h0,    32'h0,        32'h0};
        tbl[11] = '{32'h0000_0008, 32'h0,        1, 0, 3'b110, 1,  0,  32'h8000_0000, 0, 4'hF,   32'h0,        32'h8000_0000};
        tbl[12] = '{32'h0000_0020, 32'h0,        1, 0, 3'b010, 1,  9,  32'h0,        0, 4'hF,   32'h0,        32'h0};
        tbl[13] = '{32'h0000_0040, 32'h0,        1, 0, 3'b000, 0,  0,  32'h0000_007F, 0, 4'hF,   32'h0,        32'h0000_007F};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", dm_req_o, 1'b0);
        chk("rst_we", dm_we_o, 1'b0);
        chk("rst_addr", dm_addr_o, 32'h0);
        chk("rst_be", dm_be_o, 4'h0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_alu_o", alu_o, 32'h0);
        chk("rst_d_mem", d_mem_o, 32'h0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_bus_err", bus_err_o, 1'b0);
        rst_n = 1'b1;
        step();

        foreach (tbl[i])
            run_txn(1'b1, tbl[i].alu, tbl[i].rs2, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].sel,
                    tbl[i].delay, tbl[i].rdata, tbl[i].mis, tbl[i].be, tbl[i].wdata, tbl[i].dmem);

        // Ack arriving while idle must not produce a result.
        dm_ack_i = 1'b1;
        step();
        dm_ack_i = 1'b0;
        chk("idle_ack_wb_valid", wb_valid_o, 1'b0);
        chk("idle_ack_req", dm_req_o, 1'b0);

        // Reset asserted mid-transaction, then a stale ack after release.
        ex_valid_i = 1'b1;
        alu_i      = 32'h0000_0400;
        mem_rd_i   = 1'b1;
        funct3_i   = 3'b010;
        step();
        ex_valid_i = 1'b0;
        mem_rd_i   = 1'b0;
        chk("mid_req_before", dm_req_o, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", dm_req_o, 1'b0);
        chk("mid_rst_stall", stall_o, 1'b0);
        #1;
        rst_n      = 1'b1;
        dm_ack_i   = 1'b1;
        dm_rdata_i = 32'hCAFE_F00D;
        step();
        dm_ack_i = 1'b0;
        chk("late_ack_wb_valid", wb_valid_o, 1'b0);
        chk("late_ack_stall", stall_o, 1'b0);
        step();
        chk("late_ack_wb_valid2", wb_valid_o, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic        vld;
            logic [31:0] alu;
            logic [31:0] rs2;
            logic [31:0] rdata;
            logic [2:0]  f3;
            logic        rd;
            logic        wr;
            logic        sel;
            logic        mis;
            logic [3:0]  be;
            logic [31:0] wdata;
            logic [31:0] dmem;
            int          ty;
            int          sz;
            int          dly;
            vld   = ($urandom_range(0, 9) != 0);
            alu   = $urandom;
            rs2   = $urandom;
            rdata = $urandom;
            f3    = 3'($urandom_range(0, 7));
            ty    = $urandom_range(0, 2);
            rd    = (ty == 1);
            wr    = (ty == 2);
            sel   = 1'($urandom_range(0, 1));
            dly   = $urandom_range(0, 5);
            sz    = size_of(f3);
            mis   = ((alu % sz) != 0);
            be    = rd ? 4'hF : 4'(((1 << sz) - 1) << (alu % 4));
            if (sz == 1)      wdata = (rs2 % 256) * 32'h0101_0101;
            else if (sz == 2) wdata = (rs2 % 65536) * 32'h0001_0001;
            else              wdata = rs2;
            dmem  = rd ? ref_load(rdata, int'(alu % 4), f3) : 32'h0;
            run_txn(vld, alu, rs2, rd, wr, f3, sel, dly, rdata, mis, be, wdata, dmem);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
